me_scan_ctrl_p: RTL and testbench
=================================

// Module: me_scan_ctrl_p
// PURPOSE
//  Parametrised full-search block-matching controller. Sequences the current-block load and the search-window
//  prefetch, then serpentine-scans all candidate positions. Drives the per-bank addresses and read enables of
//  BLK+1 rotating search banks, plus delay-aligned candidate tags for the SAD array and best-match comparator.
//  Adds over the prior generation: runtime search range, start/busy/done handshake, parametrised pipeline alignment.
// PARAMETERS
//  BLK      16  block edge in pixels; search memory has BLK+1 banks
//  RANGE    32  max candidate positions per axis (power of 2)
//  AW        8  bank address width
//  MEM_LAT   1  search-bank read latency, cycles
//  PE_LAT    5  SAD-array latency from bank data to SAD valid, cycles
// PORTS
//  clk        in   1             clock
//  reset      in   1             asynchronous, active-high reset
//  start      in   1             begin search; sampled only in IDLE/DONE
//  stop       in   1             abort: force DONE next cycle
//  cfg_range  in   $clog2(RANGE)+1  active range R (1..RANGE), latched on accepted start
//  busy       out  1             high from accepted start until DONE entered
//  done       out  1             one-cycle pulse on DONE entry (normal or aborted)
//  cmp_init   out  1             comparator clear, one cycle, MEM_LAT cycles after LOAD_SRCH ends
//  bank_rd_en out  BLK+1         per-bank read enable
//  bank_addr  out  (BLK+1)*AW    packed bank addresses, bank k at [k*AW +: AW]
//  col_order  out  $clog2(BLK+1) bank rotation, delayed MEM_LAT to align with bank data
//  pf_en      out  1             extra-column prefetch flag, delayed MEM_LAT
//  sad_valid  out  1             candidate SAD valid, delayed MEM_LAT+PE_LAT from issue
//  sad_x/sad_y out $clog2(RANGE) candidate tag, delayed MEM_LAT+PE_LAT from issue
// BEHAVIOUR
//  Reset: FSM=IDLE, all counters 0, all outputs 0.
//  FSM: IDLE -start-> LD_CUR (BLK cycles) -> LD_SRCH (BLK cycles) -> SCAN -> DONE; DONE -start-> LD_CUR.
//  stop has priority over everything except reset; from any state the next state is DONE and done pulses once
//    (no pulse if already in DONE or IDLE). Counters clear on DONE entry.
//  LD_CUR/LD_SRCH: cnt 0..BLK-1; bank_addr all = cnt; rd_en = all ones in LD_SRCH, zero in LD_CUR.
//  SCAN: one candidate issued per cycle, R*R cycles total. Direction dir=down at x=0. Down: y 0->R-1; Up: y R-1->0.
//    At end of a column: x==R-1 -> DONE; else x+1, dir toggles, y holds (same y issued again at new x).
//  order = x mod (BLK+1); page = (x div (BLK+1))*(R+BLK-1); row = page + BLK + y (wrap mod 2^AW).
//  bank k addr = row + (k < order ? (R+BLK-1) : 0).
//  rd_en in SCAN: all banks except k = (order+BLK) mod (BLK+1); pf = (y-progress in column >= BLK-1) && x!=R-1;
//    pf forces all ones. rd_en = 0 outside LD_SRCH/SCAN.
//  cmp_init, col_order, pf_en: MEM_LAT-stage shift. sad_valid/sad_x/sad_y: MEM_LAT+PE_LAT-stage shift of
//    (scan issue, x, y); sad_valid=1 exactly R*R times per full search.
//  Aborted search: pipeline keeps draining already-issued tags; no new issue after stop.
//  start during LD_*/SCAN ignored. start and stop together in IDLE: stop wins (go DONE).
// STRUCTURE
//  Package me_pkg: state enum (IDLE, LD_CUR, LD_SRCH, SCAN, DONE), BLK/RANGE defaults, bank-index/width functions.
//  Sub-module me_delay_line #(W, DEPTH): reset-free shift register, DEPTH=0 passes through; used for all alignment.
// TESTING
//  Reset mid-SCAN -> next cycle busy=0, sad_valid=0, all rd_en=0, FSM IDLE.
//  BLK=16, RANGE=32, cfg_range=32, start -> done 32+1024+1 cycles later; sad_valid count 1024; last tag (31,0).
//  cfg_range=4 -> tags in order (0,0..3),(1,3..0),(2,0..3),(3,3..0); 16 valids.
//  x=17, y=0, BLK=16 -> order=0, page=47; bank0 addr=63; rd_en=all except bank16.
//  stop at SCAN cycle 100 -> done pulses once; exactly 100 sad_valid pulses after drain; next start restarts at (0,0).
//  MEM_LAT=2, PE_LAT=3 -> first sad_valid 5 cycles after first SCAN cycle; cmp_init 2 cycles after LD_SRCH ends.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and sizing helpers for the motion-estimation scan controller.
package me_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_CUR,
      LD_SRCH,
      SCAN,
      DONE
   } state_t;

   localparam int BLK_D   = 16;
   localparam int RANGE_D = 32;

   function automatic int bank_w(input int blk);
      return $clog2(blk + 1);
   endfunction

   function automatic int tag_w(input int range);
      return $clog2(range);
   endfunction

endpackage

// File: rtl/me_scan_ctrl_p_if.sv
// Control handshake plus bank and SAD-tag bus of the scan controller.
interface me_scan_ctrl_p_if
   import me_pkg::*;
#(
   parameter int BLK   = BLK_D,
   parameter int RANGE = RANGE_D,
   parameter int AW    = 8
);

   localparam int TW = tag_w(RANGE);
   localparam int OW = bank_w(BLK);
   localparam int RW = TW + 1;

   logic                  start;
   logic                  stop;
   logic [RW-1:0]         cfg_range;
   logic                  busy;
   logic                  done;
   logic                  cmp_init;
   logic [BLK:0]          bank_rd_en;
   logic [(BLK+1)*AW-1:0] bank_addr;
   logic [OW-1:0]         col_order;
   logic                  pf_en;
   logic                  sad_valid;
   logic [TW-1:0]         sad_x;
   logic [TW-1:0]         sad_y;

   modport master (
      output start, stop, cfg_range,
      input  busy, done, cmp_init, bank_rd_en, bank_addr,
      input  col_order, pf_en, sad_valid, sad_x, sad_y
   );

   modport slave (
      input  start, stop, cfg_range,
      output busy, done, cmp_init, bank_rd_en, bank_addr,
      output col_order, pf_en, sad_valid, sad_x, sad_y
   );

endinterface

// File: rtl/me_delay_line.sv
// Reset-free alignment shift register; DEPTH of zero is a wire.
module me_delay_line #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (DEPTH == 0) begin : g_pass
      assign q = d;
   end else begin : g_sr
      logic [W-1:0] sr [DEPTH];
      always_ff @(posedge clk) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
      assign q = sr[DEPTH-1];
   end

endmodule

// File: rtl/me_scan_ctrl_p.sv
// Full-search block-matching controller: loads, serpentine scan, bank addressing.
module me_scan_ctrl_p
   import me_pkg::*;
#(
   parameter int BLK     = BLK_D,
   parameter int RANGE   = RANGE_D,
   parameter int AW      = 8,
   parameter int MEM_LAT = 1,
   parameter int PE_LAT  = 5
) (
   input  logic            clk,
   input  logic            reset,
   me_scan_ctrl_p_if.slave bus
);

   localparam int TW = tag_w(RANGE);
   localparam int OW = bank_w(BLK);
   localparam int RW = TW + 1;
   localparam int CW = $clog2(BLK);
   localparam int NB = BLK + 1;
   localparam int PL = MEM_LAT + PE_LAT;
   localparam int SW = $clog2(PL + 2);

   state_t        state, nxt;
   logic [CW-1:0] cnt;
   logic [TW-1:0] x, y, ym, prog;
   logic          dir, col_end, last, ld, issue, pf;
   logic          scan_first, done_q;
   logic [OW-1:0] ord, dead;
   logic [AW-1:0] page, row, stride;
   logic [RW-1:0] rng;
   logic [SW-1:0] since;

   assign ym      = TW'(rng - RW'(1));
   assign col_end = dir ? (y == '0) : (y == ym);
   assign last    = col_end && (x == ym);
   assign ld      = (state == LD_CUR) || (state == LD_SRCH);
   assign issue   = (state == SCAN) && !bus.stop;
   assign prog    = dir ? (ym - y) : y;
   assign pf      = (state == SCAN) && (32'(prog) >= 32'(BLK - 1)) && (x != ym);
   assign stride  = AW'(rng) + AW'(BLK - 1);
   assign row     = page + AW'(BLK) + AW'(y);
   assign dead    = (ord == '0) ? OW'(BLK) : ord - OW'(1);

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE: if (bus.start) nxt = LD_CUR;
         LD_CUR:     if (cnt == CW'(BLK - 1)) nxt = LD_SRCH;
         LD_SRCH:    if (cnt == CW'(BLK - 1)) nxt = SCAN;
         SCAN:       if (last) nxt = DONE;
         default:    nxt = IDLE;
      endcase
      if (bus.stop) nxt = DONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         x          <= '0;
         y          <= '0;
         dir        <= 1'b0;
         ord        <= '0;
         page       <= '0;
         rng        <= '0;
         since      <= '0;
         scan_first <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= (nxt == DONE) && (state != DONE) && (state != IDLE);
         scan_first <= (state == LD_SRCH) && (nxt == SCAN);
         if (since != SW'(PL)) since <= since + SW'(1);
         if ((state == IDLE || state == DONE) && nxt == LD_CUR)
            rng <= bus.cfg_range;
         if (nxt != state) begin
            cnt  <= '0;
            x    <= '0;
            y    <= '0;
            dir  <= 1'b0;
            ord  <= '0;
            page <= '0;
         end else if (ld) begin
            cnt <= cnt + CW'(1);
         end else if (state == SCAN) begin
            if (col_end) begin
               // y holds: the turn re-issues the same row at the next column
               x   <= x + TW'(1);
               dir <= ~dir;
               if (ord == OW'(BLK)) begin
                  ord  <= '0;
                  page <= page + stride;
               end else begin
                  ord <= ord + OW'(1);
               end
            end else begin
               y <= dir ? y - TW'(1) : y + TW'(1);
            end
         end
      end
   end

   always_comb begin
      bus.bank_rd_en = '0;
      bus.bank_addr  = '0;
      if (ld) begin
         for (int k = 0; k < NB; k++) bus.bank_addr[k*AW +: AW] = AW'(cnt);
         if (state == LD_SRCH) bus.bank_rd_en = '1;
      end else if (state == SCAN) begin
         for (int k = 0; k < NB; k++)
            bus.bank_addr[k*AW +: AW] = row + ((OW'(k) < ord) ? stride : '0);
         bus.bank_rd_en = '1;
         if (!pf) bus.bank_rd_en[dead] = 1'b0;
      end
   end

   logic [OW+1:0] m_d, m_q;
   logic [2*TW:0] s_d, s_q;
   logic          m_ok, s_ok;

   assign m_d = {scan_first, pf, (state == SCAN) ? ord : '0};
   assign s_d = {issue, x, y};

   me_delay_line #(.W(OW + 2), .DEPTH(MEM_LAT)) u_mem_dl (
      .clk (clk),
      .d   (m_d),
      .q   (m_q)
   );

   me_delay_line #(.W(2 * TW + 1), .DEPTH(PL)) u_sad_dl (
      .clk (clk),
      .d   (s_d),
      .q   (s_q)
   );

   // the lines are reset-free; mask them until refilled since reset
   assign m_ok = since >= SW'(MEM_LAT);
   assign s_ok = since == SW'(PL);

   assign bus.cmp_init  = m_ok & m_q[OW+1];
   assign bus.pf_en     = m_ok & m_q[OW];
   assign bus.col_order = m_ok ? m_q[OW-1:0] : '0;
   assign bus.sad_valid = s_ok & s_q[2*TW];
   assign bus.sad_x     = s_ok ? s_q[2*TW-1:TW] : '0;
   assign bus.sad_y     = s_ok ? s_q[TW-1:0] : '0;
   assign bus.busy      = ld || (state == SCAN);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_me_scan_ctrl_p.sv
// Directed bench for me_scan_ctrl_p with a tag scoreboard.
module tb_me_scan_ctrl_p;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   me_scan_ctrl_p_if #(.BLK(16), .RANGE(32), .AW(8)) a_if ();
   me_scan_ctrl_p_if #(.BLK(4), .RANGE(8), .AW(8)) b_if ();

   me_scan_ctrl_p #(
      .BLK(16), .RANGE(32), .AW(8), .MEM_LAT(1), .PE_LAT(5)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   me_scan_ctrl_p #(
      .BLK(4), .RANGE(8), .AW(8), .MEM_LAT(2), .PE_LAT(3)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   int checks = 0;
   int errors = 0;
   int q[$];
   int vcnt = 0;
   int bcnt = 0;
   int last_tag = -1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // serpentine reference: even columns walk y up, odd columns walk y down
   task automatic push_model(input int r);
      for (int xx = 0; xx < r; xx++)
         for (int i = 0; i < r; i++)
            q.push_back((xx << 8) | ((xx % 2 != 0) ? (r - 1 - i) : i));
   endtask

   task automatic wait_done(input int lim, output int n);
      n = 1;
      while (a_if.done !== 1'b1 && n < lim) begin
         tick(1);
         n++;
      end
   endtask

   always @(negedge clk) begin : mon_a
      int t, e;
      if (!reset && a_if.sad_valid === 1'b1) begin
         t = (32'(a_if.sad_x) << 8) | 32'(a_if.sad_y);
         vcnt++;
         last_tag = t;
         e = (q.size() != 0) ? q.pop_front() : -1;
         chk("sb_tag", 32'(t), 32'(e));
      end
   end

   always @(negedge clk)
      if (!reset && b_if.sad_valid === 1'b1) bcnt++;

   initial begin
      int n, cmpn, svn;
      reset = 1'b1;
      a_if.start = 1'b0; a_if.stop = 1'b0; a_if.cfg_range = 6'd32;
      b_if.start = 1'b0; b_if.stop = 1'b0; b_if.cfg_range = 4'd8;
      tick(3);
      chk("rst_busy", 32'(a_if.busy), 0);
      chk("rst_done", 32'(a_if.done), 0);
      chk("rst_rd_en", 32'(a_if.bank_rd_en), 0);
      chk("rst_addr0", 32'(a_if.bank_addr[7:0]), 0);
      chk("rst_sad_valid", 32'(a_if.sad_valid), 0);
      chk("rst_cmp_init", 32'(a_if.cmp_init), 0);
      reset = 1'b0;
      tick(2);

      // short pipeline instance: latency of cmp_init and first SAD
      b_if.start = 1'b1; tick(1); b_if.start = 1'b0;
      n = 1; cmpn = 0; svn = 0;
      while (b_if.done !== 1'b1 && n < 300) begin
         if (cmpn == 0 && b_if.cmp_init === 1'b1) cmpn = n;
         if (svn == 0 && b_if.sad_valid === 1'b1) begin
            svn = n;
            chk("b_first_tag", 32'({b_if.sad_x, b_if.sad_y}), 0);
         end
         tick(1);
         n++;
      end
      chk("b_cmp_init_lat", 32'(cmpn), 11);
      chk("b_sad_valid_lat", 32'(svn), 14);
      chk("b_done_lat", 32'(n), 73);
      tick(8);
      chk("b_valid_count", 32'(bcnt), 64);

      // start together with stop in IDLE: goes to DONE silently
      a_if.start = 1'b1; a_if.stop = 1'b1; tick(1);
      a_if.start = 1'b0; a_if.stop = 1'b0;
      chk("idle_stop_done", 32'(a_if.done), 0);
      chk("idle_stop_busy", 32'(a_if.busy), 0);

      // full search R=32 with address/enable probes
      push_model(32); vcnt = 0;
      a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
      n = 1;
      while (a_if.done !== 1'b1 && n < 3000) begin
         case (n)
            1: begin
               chk("ldcur_rd_en", 32'(a_if.bank_rd_en), 0);
               chk("ldcur_busy", 32'(a_if.busy), 1);
            end
            17: chk("ldsrch_rd_en", 32'(a_if.bank_rd_en), 32'h1FFFF);
            20: chk("ldsrch_addr5", 32'(a_if.bank_addr[5*8 +: 8]), 3);
            33: begin
               chk("scan0_rd_en", 32'(a_if.bank_rd_en), 32'h0FFFF);
               chk("scan0_addr0", 32'(a_if.bank_addr[7:0]), 16);
               chk("scan0_cmp_init", 32'(a_if.cmp_init), 0);
            end
            34: chk("cmp_init_on", 32'(a_if.cmp_init), 1);
            35: chk("cmp_init_off", 32'(a_if.cmp_init), 0);
            47: chk("pre_pf_rd_en", 32'(a_if.bank_rd_en), 32'h0FFFF);
            48: begin
               chk("pf_rd_en", 32'(a_if.bank_rd_en), 32'h1FFFF);
               chk("pf_en_lag", 32'(a_if.pf_en), 0);
            end
            49: chk("pf_en_on", 32'(a_if.pf_en), 1);
            577: begin
               chk("x17_top_addr0", 32'(a_if.bank_addr[7:0]), 94);
               chk("x17_top_rd_en", 32'(a_if.bank_rd_en), 32'h0FFFF);
            end
            578: chk("x17_col_order", 32'(a_if.col_order), 0);
            608: begin
               chk("x17_y0_addr0", 32'(a_if.bank_addr[7:0]), 63);
               chk("x17_y0_addr16", 32'(a_if.bank_addr[16*8 +: 8]), 63);
            end
            609: begin
               chk("x18_addr0", 32'(a_if.bank_addr[7:0]), 110);
               chk("x18_addr1", 32'(a_if.bank_addr[15:8]), 63);
               chk("x18_rd_en", 32'(a_if.bank_rd_en), 32'h1FFFE);
            end
            610: chk("x18_col_order", 32'(a_if.col_order), 1);
            1045: chk("last_col_no_pf", 32'(a_if.bank_rd_en), 32'h1DFFF);
            default: ;
         endcase
         tick(1);
         n++;
      end
      chk("full_done_lat", 32'(n), 1057);
      chk("full_busy_off", 32'(a_if.busy), 0);
      tick(1);
      chk("full_done_pulse", 32'(a_if.done), 0);
      tick(8);
      chk("full_valid_count", 32'(vcnt), 1024);
      chk("full_last_tag", 32'(last_tag), 32'h1F00);
      chk("full_sb_empty", 32'(q.size()), 0);

      // reset in the middle of SCAN
      push_model(32); vcnt = 0;
      a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
      tick(60);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(a_if.busy), 0);
      chk("mid_rst_sad_valid", 32'(a_if.sad_valid), 0);
      chk("mid_rst_rd_en", 32'(a_if.bank_rd_en), 0);
      tick(1);
      chk("mid_rst_done", 32'(a_if.done), 0);
      q.delete();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("post_rst_sad_valid", 32'(a_if.sad_valid), 0);
      end
      chk("post_rst_rd_en", 32'(a_if.bank_rd_en), 0);

      // small range: exact serpentine order
      a_if.cfg_range = 6'd4;
      push_model(4); vcnt = 0;
      a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
      a_if.cfg_range = 6'd32;
      wait_done(500, n);
      chk("r4_done_lat", 32'(n), 49);
      tick(8);
      chk("r4_valid_count", 32'(vcnt), 16);
      chk("r4_sb_empty", 32'(q.size()), 0);

      // abort at SCAN cycle 100
      push_model(32); vcnt = 0;
      a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
      tick(132);
      a_if.stop = 1'b1; tick(1); a_if.stop = 1'b0;
      chk("abort_done", 32'(a_if.done), 1);
      chk("abort_busy", 32'(a_if.busy), 0);
      tick(1);
      chk("abort_done_pulse", 32'(a_if.done), 0);
      tick(8);
      chk("abort_valid_count", 32'(vcnt), 100);
      chk("abort_sb_left", 32'(q.size()), 924);
      q.delete();

      // restart after abort begins again at (0,0)
      push_model(32); vcnt = 0;
      a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
      wait_done(3000, n);
      chk("restart_done_lat", 32'(n), 1057);
      tick(8);
      chk("restart_valid_count", 32'(vcnt), 1024);
      chk("restart_sb_empty", 32'(q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
